// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared phase, lamp and fault encodings for the traffic-light lamp bus
package traffic_light_pkg;

  localparam logic [1:0] PH_SYNC   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  typedef enum logic [2:0] {
    L_DARK  = 3'd0,
    L_R     = 3'd1,
    L_G     = 3'd2,
    L_Y     = 3'd3,
    L_MULTI = 3'd4
  } lamp_e;

  typedef enum logic [2:0] {
    F_NONE  = 3'd0,
    F_MULTI = 3'd1,
    F_DARK  = 3'd2,
    F_ORDER = 3'd3,
    F_SHORT = 3'd4,
    F_LONG  = 3'd5
  } fault_e;

endpackage

// File: rtl/tl_lamp_decode.sv
// rtl/tl_lamp_decode.sv - maps the raw {red,yellow,green} lines to a single lamp symbol
module tl_lamp_decode
  import traffic_light_pkg::*;
(
  input  logic  red_i,
  input  logic  yellow_i,
  input  logic  green_i,
  output lamp_e lamp_o
);

  always_comb begin
    case ({red_i, yellow_i, green_i})
      3'b100:  lamp_o = L_R;
      3'b001:  lamp_o = L_G;
      3'b010:  lamp_o = L_Y;
      3'b000:  lamp_o = L_DARK;
      default: lamp_o = L_MULTI;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks lamp phase order and dwell times, latches the first fault
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 32,
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 7,
  parameter int TOL           = 1,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
  input  logic        clear_fault,
  output logic [1:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        cycle_done,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {ST_SYNC, ST_RED, ST_GREEN, ST_YELLOW, ST_FAULT} state_e;

  localparam logic [CNT_W-1:0] RED_HI = CNT_W'(RED_CYCLES + TOL);
  localparam logic [CNT_W-1:0] GRN_HI = CNT_W'(GREEN_CYCLES + TOL);
  localparam logic [CNT_W-1:0] YEL_HI = CNT_W'(YELLOW_CYCLES + TOL);
  localparam logic [CNT_W-1:0] RED_LO = CNT_W'((RED_CYCLES > TOL) ? RED_CYCLES - TOL : 0);
  localparam logic [CNT_W-1:0] GRN_LO = CNT_W'((GREEN_CYCLES > TOL) ? GREEN_CYCLES - TOL : 0);
  localparam logic [CNT_W-1:0] YEL_LO = CNT_W'((YELLOW_CYCLES > TOL) ? YELLOW_CYCLES - TOL : 0);

  state_e           state_q;
  logic [CNT_W-1:0] dwell_q;
  logic             first_q;
  logic [1:0]       phase_q;
  logic             fault_q;
  fault_e           fault_code_q;
  logic             cycle_done_q;
  logic [15:0]      cycle_count_q;

  lamp_e            lamp;
  lamp_e            cur_lamp;
  lamp_e            nxt_lamp;
  state_e           nxt_state;
  logic [1:0]       nxt_phase;
  logic [CNT_W-1:0] nom_hi;
  logic [CNT_W-1:0] nom_lo;
  logic [CNT_W-1:0] dwell_d;
  fault_e           cause;
  logic             hold;
  logic             advance;

  tl_lamp_decode u_decode (
    .red_i    (red),
    .yellow_i (yellow),
    .green_i  (green),
    .lamp_o   (lamp)
  );

  always_comb begin
    cur_lamp  = L_DARK;
    nxt_lamp  = L_DARK;
    nxt_state = ST_SYNC;
    nxt_phase = PH_SYNC;
    nom_hi    = '0;
    nom_lo    = '0;
    case (state_q)
      ST_RED:    begin cur_lamp = L_R; nxt_lamp = L_G; nxt_state = ST_GREEN;
                       nxt_phase = PH_GREEN;  nom_hi = RED_HI; nom_lo = RED_LO; end
      ST_GREEN:  begin cur_lamp = L_G; nxt_lamp = L_Y; nxt_state = ST_YELLOW;
                       nxt_phase = PH_YELLOW; nom_hi = GRN_HI; nom_lo = GRN_LO; end
      ST_YELLOW: begin cur_lamp = L_Y; nxt_lamp = L_R; nxt_state = ST_RED;
                       nxt_phase = PH_RED;    nom_hi = YEL_HI; nom_lo = YEL_LO; end
      default:   ;
    endcase
  end

  // Each sample yields one cause at most, so the priority order falls out of the if-chain.
  always_comb begin
    dwell_d = (&dwell_q) ? dwell_q : dwell_q + CNT_W'(1);
    cause   = F_NONE;
    hold    = 1'b0;
    advance = 1'b0;
    if (state_q == ST_SYNC) begin
      if (lamp == L_MULTI) cause = F_MULTI;
    end else if (state_q != ST_FAULT) begin
      if (lamp == L_MULTI)           cause = F_MULTI;
      else if (lamp == L_DARK)       cause = F_DARK;
      else if (lamp == cur_lamp) begin
        hold = 1'b1;
        if (dwell_d > nom_hi)        cause = F_LONG;
      end else if (lamp == nxt_lamp) begin
        if (!first_q && dwell_q < nom_lo) cause = F_SHORT;
        else                         advance = 1'b1;
      end else                       cause = F_ORDER;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_SYNC;
      dwell_q       <= '0;
      first_q       <= 1'b1;
      phase_q       <= PH_SYNC;
      fault_q       <= 1'b0;
      fault_code_q  <= F_NONE;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      cycle_done_q <= 1'b0;
      if (state_q == ST_FAULT) begin
        if (clear_fault) begin
          state_q      <= ST_SYNC;
          fault_q      <= 1'b0;
          fault_code_q <= F_NONE;
          dwell_q      <= '0;
          first_q      <= 1'b1;
        end
      end else if (enable) begin
        if (cause != F_NONE) begin
          state_q      <= ST_FAULT;
          fault_q      <= 1'b1;
          fault_code_q <= cause;
          phase_q      <= PH_SYNC;
        end else if (state_q == ST_SYNC) begin
          if (lamp == L_R) begin
            state_q <= ST_RED;
            phase_q <= PH_RED;
            dwell_q <= CNT_W'(1);
            first_q <= 1'b1;
          end
        end else if (hold) begin
          dwell_q <= dwell_d;
        end else if (advance) begin
          state_q <= nxt_state;
          phase_q <= nxt_phase;
          dwell_q <= CNT_W'(1);
          first_q <= 1'b0;
          if (state_q == ST_YELLOW) begin
            cycle_done_q <= 1'b1;
            if (cycle_count_q != 16'hFFFF) cycle_count_q <= cycle_count_q + 16'd1;
          end
        end
      end
    end
  end

  assign phase       = phase_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign cycle_done  = cycle_done_q;
  assign cycle_count = cycle_count_q;

endmodule
